// File: rtl/rtc_pkg.sv
// Shared definitions for the time-of-day counter.
//   rtc_state_e : controller states (IDLE / RUN / LOAD)
//   SEC_MOD     : seconds field modulus
//   MIN_MOD     : minutes field modulus
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10
  } rtc_state_e;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

endpackage

// File: rtl/rtc_tick_gen.sv
// One-second prescaler for the time-of-day counter.
// Counts 0..TICK_DIV-1 while run=1 and emits a tick on the terminal count.
// The count holds while run=0, so a paused clock keeps its partial second.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   run   : advance the prescaler this cycle
//   clear : force the prescaler back to 0 (has priority over run)
//   tick  : combinational, high on the terminal count while run=1
module rtc_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // A divide-by-one prescaler still needs a 1-bit register to stay legal.
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_time_counter.sv
// Hours/minutes/seconds time-of-day counter with pause, preset load and
// registered rollover strobes.
//   clk, reset                 : system clock, asynchronous active-high reset
//   enable                     : run request (level)
//   set                        : load request, priority over enable
//   setHr, setMin, setSec      : preset values captured when set=1
//   countHr, countMin, countSec: current time, binary
//   minPulse, hrPulse, dayPulse: one-cycle strobes, coincident with the wrap
//   running                    : high exactly in RUN cycles
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOURS    = 24,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             set,
  input  logic [WIDTH-1:0] setHr,
  input  logic [WIDTH-1:0] setMin,
  input  logic [WIDTH-1:0] setSec,
  output logic [WIDTH-1:0] countHr,
  output logic [WIDTH-1:0] countMin,
  output logic [WIDTH-1:0] countSec,
  output logic             minPulse,
  output logic             hrPulse,
  output logic             dayPulse,
  output logic             running
);

  localparam logic [WIDTH-1:0] HR_MOD_W  = WIDTH'(HOURS);
  localparam logic [WIDTH-1:0] MIN_MOD_W = WIDTH'(MIN_MOD);
  localparam logic [WIDTH-1:0] SEC_MOD_W = WIDTH'(SEC_MOD);
  localparam logic [WIDTH-1:0] HR_LAST   = WIDTH'(HOURS - 1);
  localparam logic [WIDTH-1:0] MIN_LAST  = WIDTH'(MIN_MOD - 1);
  localparam logic [WIDTH-1:0] SEC_LAST  = WIDTH'(SEC_MOD - 1);

  rtc_state_e       state_q, state_d;
  logic [WIDTH-1:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [WIDTH-1:0] pre_hr_q, pre_hr_d, pre_min_q, pre_min_d, pre_sec_q, pre_sec_d;
  logic             min_pulse_q, min_pulse_d;
  logic             hr_pulse_q, hr_pulse_d;
  logic             day_pulse_q, day_pulse_d;
  logic             running_q;
  logic             tick;
  logic             advance;

  rtc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .clear (state_q == ST_LOAD),
    .tick  (tick)
  );

  // A set request arriving on a tick cycle wins: that tick is dropped.
  assign advance = tick && !set;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (set)         state_d = ST_LOAD;
        else if (enable) state_d = ST_RUN;
        else             state_d = ST_IDLE;
      end
      ST_LOAD: state_d = enable ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Presets are captured on the set edge and written to the counters during
  // LOAD. Each field is range-checked on its own; out-of-range loads zero.
  always_comb begin
    pre_hr_d  = pre_hr_q;
    pre_min_d = pre_min_q;
    pre_sec_d = pre_sec_q;
    if (set && (state_q != ST_LOAD)) begin
      pre_hr_d  = (setHr  < HR_MOD_W)  ? setHr  : '0;
      pre_min_d = (setMin < MIN_MOD_W) ? setMin : '0;
      pre_sec_d = (setSec < SEC_MOD_W) ? setSec : '0;
    end
  end

  // Cascaded mod counters; each strobe is set in the same cycle as its wrap.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    min_pulse_d = 1'b0;
    hr_pulse_d  = 1'b0;
    day_pulse_d = 1'b0;
    if (state_q == ST_LOAD) begin
      sec_d = pre_sec_q;
      min_d = pre_min_q;
      hr_d  = pre_hr_q;
    end else if (advance) begin
      if (sec_q == SEC_LAST) begin
        sec_d       = '0;
        min_pulse_d = 1'b1;
        if (min_q == MIN_LAST) begin
          min_d      = '0;
          hr_pulse_d = 1'b1;
          if (hr_q == HR_LAST) begin
            hr_d        = '0;
            day_pulse_d = 1'b1;
          end else begin
            hr_d = hr_q + WIDTH'(1);
          end
        end else begin
          min_d = min_q + WIDTH'(1);
        end
      end else begin
        sec_d = sec_q + WIDTH'(1);
      end
    end
  end

  // NOTE: the preset holding registers are reset along with everything else;
  // they are few, and it keeps a LOAD after reset deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hr_q        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      pre_hr_q    <= '0;
      pre_min_q   <= '0;
      pre_sec_q   <= '0;
      min_pulse_q <= 1'b0;
      hr_pulse_q  <= 1'b0;
      day_pulse_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      pre_hr_q    <= pre_hr_d;
      pre_min_q   <= pre_min_d;
      pre_sec_q   <= pre_sec_d;
      min_pulse_q <= min_pulse_d;
      hr_pulse_q  <= hr_pulse_d;
      day_pulse_q <= day_pulse_d;
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign countHr  = hr_q;
  assign countMin = min_q;
  assign countSec = sec_q;
  assign minPulse = min_pulse_q;
  assign hrPulse  = hr_pulse_q;
  assign dayPulse = day_pulse_q;
  assign running  = running_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter. Three instances share all inputs:
//   A: TICK_DIV=4,  HOURS=24
//   B: TICK_DIV=1,  HOURS=24
//   C: TICK_DIV=10, HOURS=12
// A reference model keeps the time of day as a single seconds-of-day integer
// per instance and is compared against every instance on every cycle.
module tb_rtc_time_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       set = 1'b0;
  logic [7:0] set_hr = '0, set_min = '0, set_sec = '0;

  logic [7:0] a_hr, a_min, a_sec, b_hr, b_min, b_sec, c_hr, c_min, c_sec;
  logic       a_mp, a_hp, a_dp, a_run, b_mp, b_hp, b_dp, b_run, c_mp, c_hp, c_dp, c_run;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtc_time_counter #(.TICK_DIV(4), .HOURS(24), .WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .set(set),
    .setHr(set_hr), .setMin(set_min), .setSec(set_sec),
    .countHr(a_hr), .countMin(a_min), .countSec(a_sec),
    .minPulse(a_mp), .hrPulse(a_hp), .dayPulse(a_dp), .running(a_run));

  rtc_time_counter #(.TICK_DIV(1), .HOURS(24), .WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .set(set),
    .setHr(set_hr), .setMin(set_min), .setSec(set_sec),
    .countHr(b_hr), .countMin(b_min), .countSec(b_sec),
    .minPulse(b_mp), .hrPulse(b_hp), .dayPulse(b_dp), .running(b_run));

  rtc_time_counter #(.TICK_DIV(10), .HOURS(12), .WIDTH(8)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .set(set),
    .setHr(set_hr), .setMin(set_min), .setSec(set_sec),
    .countHr(c_hr), .countMin(c_min), .countSec(c_sec),
    .minPulse(c_mp), .hrPulse(c_hp), .dayPulse(c_dp), .running(c_run));

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_LOAD} mode_e;

  mode_e m_mode [3];
  int    m_t [3];
  int    m_pre [3];
  int    m_preset [3];
  bit    m_mp [3], m_hp [3], m_dp [3], m_run [3];

  function automatic int td_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 10;
    endcase
  endfunction

  function automatic int hours_of(input int k);
    return (k == 2) ? 12 : 24;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = M_IDLE; m_t[k] = 0; m_pre[k] = 0; m_preset[k] = 0;
      m_mp[k] = 0; m_hp[k] = 0; m_dp[k] = 0; m_run[k] = 0;
    end
  endtask

  // One rising edge with the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int day;
      bit tk;
      int h, mi, s;
      day = hours_of(k) * 3600;
      tk  = (m_mode[k] == M_RUN) && (m_pre[k] == td_of(k) - 1) && !set;
      m_mp[k] = 0; m_hp[k] = 0; m_dp[k] = 0;
      if (m_mode[k] == M_LOAD) begin
        m_t[k] = m_preset[k];
      end else if (tk) begin
        m_t[k]  = (m_t[k] + 1) % day;
        m_mp[k] = (m_t[k] % 60) == 0;
        m_hp[k] = (m_t[k] % 3600) == 0;
        m_dp[k] = m_t[k] == 0;
      end
      if (m_mode[k] == M_LOAD)     m_pre[k] = 0;
      else if (m_mode[k] == M_RUN) m_pre[k] = (m_pre[k] + 1) % td_of(k);
      if (set && m_mode[k] != M_LOAD) begin
        h  = (int'(set_hr)  < hours_of(k)) ? int'(set_hr)  : 0;
        mi = (int'(set_min) < 60)          ? int'(set_min) : 0;
        s  = (int'(set_sec) < 60)          ? int'(set_sec) : 0;
        m_preset[k] = h * 3600 + mi * 60 + s;
      end
      if (m_mode[k] == M_LOAD) m_mode[k] = enable ? M_RUN : M_IDLE;
      else                     m_mode[k] = set ? M_LOAD : (enable ? M_RUN : M_IDLE);
      m_run[k] = m_mode[k] == M_RUN;
    end
  endtask

  function automatic logic [27:0] model_obs(input int k);
    return {8'(m_t[k] / 3600), 8'((m_t[k] / 60) % 60), 8'(m_t[k] % 60),
            m_mp[k], m_hp[k], m_dp[k], m_run[k]};
  endfunction

  function automatic logic [27:0] dut_obs(input int k);
    case (k)
      0:       return {a_hr, a_min, a_sec, a_mp, a_hp, a_dp, a_run};
      1:       return {b_hr, b_min, b_sec, b_mp, b_hp, b_dp, b_run};
      default: return {c_hr, c_min, c_sec, c_mp, c_hp, c_dp, c_run};
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  // Packed observation layout: {hr[8], min[8], sec[8], minP, hrP, dayP, running}.
  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d p=%b run=%b, expected %0d:%0d:%0d p=%b run=%b",
               name, got[27:20], got[19:12], got[11:4], got[3:1], got[0],
               exp[27:20], exp[19:12], exp[11:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) check($sformatf("model_inst%0d", k), dut_obs(k), model_obs(k));
  endtask

  // Advance one edge, then sample 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!reset) model_step();
    model_check();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [27:0] pack(input int h, input int mi, input int s,
                                       input logic [2:0] p, input logic r);
    return {8'(h), 8'(mi), 8'(s), p, r};
  endfunction

  // Mid-cycle asynchronous reset; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("async_reset_inst%0d", k), dut_obs(k), 28'h0);
    cycles(2);
    enable = 1'b0; set = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table (instance B) ----------------
  typedef struct {
    logic       en;
    logic       st;
    logic [7:0] sh, sm, ss;
    int         e_hr, e_min, e_sec;
    logic [2:0] e_p;
    logic       e_run;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'd23, 8'd59, 8'd58,  0,  0,  0, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,  23, 59, 58, 3'b000, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,  23, 59, 59, 3'b000, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,   0,  0,  0, 3'b111, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,   0,  0,  1, 3'b000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'd10, 8'd20, 8'd30,  0,  0,  1, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,  10, 20, 30, 3'b000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd0,  10, 20, 31, 3'b000, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,  8'd0,  8'd0,  10, 20, 32, 3'b000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd0,  8'd0,  8'd0,  10, 20, 32, 3'b000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd30, 8'd75, 8'd12, 10, 20, 32, 3'b000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'd0,  8'd0,  8'd0,   0,  0, 12, 3'b000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'd0,  8'd0,  8'd0,   0,  0, 12, 3'b000, 1'b0};

    // Power-on reset.
    model_reset();
    cycles(3);
    for (int k = 0; k < 3; k++) check($sformatf("por_inst%0d", k), dut_obs(k), 28'h0);
    reset = 1'b0;

    // Table: rollover with all strobes, load beating a tick, tick on enable
    // fall, out-of-range preset clamping.
    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en; set = vecs[i].st;
      set_hr = vecs[i].sh; set_min = vecs[i].sm; set_sec = vecs[i].ss;
      cycle();
      check($sformatf("vec%0d", i), dut_obs(1),
            pack(vecs[i].e_hr, vecs[i].e_min, vecs[i].e_sec, vecs[i].e_p, vecs[i].e_run));
    end
    enable = 1'b0; set = 1'b0;

    // TICK_DIV=4 from 00:00:00: one increment every 4 RUN cycles.
    do_reset();
    enable = 1'b1;
    cycle();
    check("td4_enter_run", dut_obs(0), pack(0, 0, 0, 3'b000, 1'b1));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("td4_wait1_%0d", i), dut_obs(0), pack(0, 0, 0, 3'b000, 1'b1));
    end
    cycle();
    check("td4_sec1", dut_obs(0), pack(0, 0, 1, 3'b000, 1'b1));
    cycles(3);
    check("td4_still_sec1", dut_obs(0), pack(0, 0, 1, 3'b000, 1'b1));
    cycle();
    check("td4_sec2", dut_obs(0), pack(0, 0, 2, 3'b000, 1'b1));

    // Reset while running at 05:17:42, then no counting until enabled.
    set = 1'b1; set_hr = 8'd5; set_min = 8'd17; set_sec = 8'd42;
    cycle();
    set = 1'b0;
    cycles(2);
    check("preload_051742", dut_obs(0), pack(5, 17, 42, 3'b000, 1'b1));
    do_reset();
    cycles(8);
    check("no_count_after_reset", dut_obs(0), 28'h0);
    enable = 1'b1;
    cycles(5);
    check("count_after_reenable", dut_obs(0), pack(0, 0, 1, 3'b000, 1'b1));

    // TICK_DIV=10 pause keeps the partial second.
    do_reset();
    enable = 1'b1;
    cycles(6);
    enable = 1'b0;
    cycles(21);
    check("paused_no_count", dut_obs(2), pack(0, 0, 0, 3'b000, 1'b0));
    enable = 1'b1;
    cycles(4);
    check("resume_before_tick", dut_obs(2), pack(0, 0, 0, 3'b000, 1'b1));
    cycle();
    check("resume_tick_after_4", dut_obs(2), pack(0, 0, 1, 3'b000, 1'b1));

    // HOURS=12 day rollover, then field clamping.
    do_reset();
    enable = 1'b1; set = 1'b1; set_hr = 8'd11; set_min = 8'd59; set_sec = 8'd59;
    cycle();
    set = 1'b0;
    cycle();
    check("h12_loaded", dut_obs(2), pack(11, 59, 59, 3'b000, 1'b1));
    cycles(9);
    check("h12_before_wrap", dut_obs(2), pack(11, 59, 59, 3'b000, 1'b1));
    cycle();
    check("h12_day_wrap", dut_obs(2), pack(0, 0, 0, 3'b111, 1'b1));
    cycle();
    check("h12_strobe_one_cycle", dut_obs(2), pack(0, 0, 0, 3'b000, 1'b1));
    enable = 1'b0; set = 1'b1; set_hr = 8'd30; set_min = 8'd75; set_sec = 8'd12;
    cycle();
    set = 1'b0;
    cycle();
    check("clamp_h12", dut_obs(2), pack(0, 0, 12, 3'b000, 1'b0));
    check("clamp_h24", dut_obs(0), pack(0, 0, 12, 3'b000, 1'b0));

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      set    = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       set_hr = 8'd11;
        1:       set_hr = 8'd23;
        default: set_hr = 8'($urandom_range(0, 130));
      endcase
      set_min = ($urandom_range(0, 1) == 0) ? 8'd59 : 8'($urandom_range(0, 99));
      set_sec = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(50, 59))
                                            : 8'($urandom_range(0, 99));
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
